// File: rtl/sys_pkg.sv
// -----------------------------------------------------------------------------
// sys_pkg
// Shared definitions for the system controller: command opcodes, operand
// register addresses and the controller state encoding.
// -----------------------------------------------------------------------------
package sys_pkg;

  // Command opcodes carried in the first byte of every RX frame.
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register file locations that feed the ALU operand inputs.
  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    RD_SEND,
    OP_A,
    OP_B,
    ALU_FN,
    ALU_WAIT,
    SEND_LO,
    SEND_HI
  } state_e;

  // States in which the controller waits on a datapath strobe and the
  // timeout counter is allowed to run.
  function automatic logic is_wait_state(input state_e s);
    return (s == RD_WAIT) || (s == ALU_WAIT);
  endfunction

endpackage

// File: rtl/sys_ctrl_timeout.sv
// -----------------------------------------------------------------------------
// sys_ctrl_timeout
// Loadable saturating up-counter used to bound waits on datapath strobes.
//   CLK      in  clock
//   RST      in  asynchronous active-low reset
//   clear    in  synchronous clear to zero (highest priority)
//   load     in  synchronous load of load_val
//   load_val in  value loaded when load is high
//   enable   in  count one step per cycle, saturating at LIMIT
//   expired  out count has reached LIMIT
// -----------------------------------------------------------------------------
module sys_ctrl_timeout #(
  parameter int LIMIT = 15,
  localparam int CW   = $clog2(LIMIT + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          enable,
  output logic          expired
);

  logic [CW-1:0] count_q;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (enable && (count_q != CW'(LIMIT))) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == CW'(LIMIT));

endmodule

// File: rtl/sys_ctrl.sv
// -----------------------------------------------------------------------------
// sys_ctrl
// Command sequencer between the UART byte streams and the register file / ALU.
// Decodes byte-framed commands (WR, RD, ALU_OP, ALU_NOP), drives the register
// file and ALU controls, and pushes response bytes toward the TX FIFO.
//   CLK, RST            clock, asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD  received byte and its one-cycle strobe
//   RdData/RdData_Valid register file read data and strobe
//   ALU_OUT/OUT_Valid   ALU result and strobe
//   FIFO_FULL           TX FIFO back-pressure
//   Address/WrEn/RdEn/WrData  register file controls (Mealy on RX_D_VLD)
//   ALU_EN/ALU_FUN/CLK_GATE_EN ALU strobe, function code, clock-gate enable
//   TX_P_DATA/TX_D_VLD  byte and write strobe toward the TX FIFO
//   CMD_ERR             one-cycle pulse on unknown opcode or timeout
// -----------------------------------------------------------------------------
module sys_ctrl
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  input  logic                    FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    CMD_ERR
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
  logic [DATA_WIDTH-1:0]   tx_q,    tx_d;
  logic [2*DATA_WIDTH-1:0] res_q,   res_d;
  logic                    tmo_expired;

  // ---------------------------------------------------------------------------
  // Timeout counter: runs only while waiting on a datapath strobe and restarts
  // on every state change.
  // ---------------------------------------------------------------------------
  sys_ctrl_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (state_d != state_q),
    .load     (1'b0),
    .load_val ('0),
    .enable   (is_wait_state(state_q)),
    .expired  (tmo_expired)
  );

  // ---------------------------------------------------------------------------
  // State and latch registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      tx_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      res_q   <= res_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    res_d       = res_q;
    Address     = '0;
    WrEn        = 1'b0;
    RdEn        = 1'b0;
    WrData      = '0;
    ALU_EN      = 1'b0;
    ALU_FUN     = '0;
    CLK_GATE_EN = 1'b0;
    TX_P_DATA   = '0;
    TX_D_VLD    = 1'b0;
    CMD_ERR     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // IDLE is also the state held during reset; gating the decode with
        // RST keeps CMD_ERR low while reset is asserted.
        if (RX_D_VLD && RST) begin
          case (RX_P_DATA)
            DATA_WIDTH'(CMD_WR):      state_d = WR_ADDR;
            DATA_WIDTH'(CMD_RD):      state_d = RD_ADDR;
            DATA_WIDTH'(CMD_ALU_OP):  state_d = OP_A;
            DATA_WIDTH'(CMD_ALU_NOP): state_d = ALU_FN;
            default:                  CMD_ERR = 1'b1;
          endcase
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      end

      WR_DATA: begin
        if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = addr_q;
          WrData  = RX_P_DATA;
          state_d = IDLE;
        end
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          RdEn    = 1'b1;
          Address = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        // A valid strobe arriving in the same cycle as expiry still wins.
        if (RdData_Valid) begin
          tx_d    = RdData;
          state_d = RD_SEND;
        end else if (tmo_expired) begin
          CMD_ERR = 1'b1;
          state_d = IDLE;
        end
      end

      RD_SEND: begin
        if (!FIFO_FULL) begin
          TX_D_VLD  = 1'b1;
          TX_P_DATA = tx_q;
          state_d   = IDLE;
        end
      end

      OP_A: begin
        if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = ADDR_WIDTH'(OPA_ADDR);
          WrData  = RX_P_DATA;
          state_d = OP_B;
        end
      end

      OP_B: begin
        if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = ADDR_WIDTH'(OPB_ADDR);
          WrData  = RX_P_DATA;
          state_d = ALU_FN;
        end
      end

      ALU_FN: begin
        CLK_GATE_EN = 1'b1;
        if (RX_D_VLD) begin
          ALU_EN  = 1'b1;
          ALU_FUN = RX_P_DATA[FUN_WIDTH-1:0];
          state_d = ALU_WAIT;
        end
      end

      ALU_WAIT: begin
        CLK_GATE_EN = 1'b1;
        if (OUT_Valid) begin
          res_d   = ALU_OUT;
          state_d = SEND_LO;
        end else if (tmo_expired) begin
          CMD_ERR = 1'b1;
          state_d = IDLE;
        end
      end

      SEND_LO: begin
        if (!FIFO_FULL) begin
          TX_D_VLD  = 1'b1;
          TX_P_DATA = res_q[DATA_WIDTH-1:0];
          state_d   = SEND_HI;
        end
      end

      SEND_HI: begin
        if (!FIFO_FULL) begin
          TX_D_VLD  = 1'b1;
          TX_P_DATA = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
- Command sequencer between the UART RX/TX byte streams and the register file / ALU datapath.
- Decodes byte-framed commands and drives Address/WrEn/RdEn/WrData of the register file. Enables and gates the ALU, then pushes response bytes toward the TX FIFO.
- Sits in the reference clock domain. RX bytes arrive already synchronised; TX bytes leave through the async FIFO.

Parameters:
- DATA_WIDTH, 8, byte width of the RX/TX/register data.
- ADDR_WIDTH, 4, register file address width.
- FUN_WIDTH, 4, ALU function code width.
- TIMEOUT, 15, maximum cycles to wait for RdData_Valid or OUT_Valid before aborting.

Ports:
- CLK  in  1  system (reference) clock.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid.
- RdData  in  DATA_WIDTH  register file read data.
- RdData_Valid  in  1  register file read-valid strobe.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- OUT_Valid  in  1  ALU result-valid strobe.
- FIFO_FULL  in  1  TX FIFO full.
- Address  out  ADDR_WIDTH  register file address.
- WrEn  out  1  register file write enable.
- RdEn  out  1  register file read enable.
- WrData  out  DATA_WIDTH  register file write data.
- ALU_EN  out  1  ALU operation strobe.
- ALU_FUN  out  FUN_WIDTH  ALU function code.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  DATA_WIDTH  byte to the TX FIFO.
- TX_D_VLD  out  1  TX FIFO write strobe.
- CMD_ERR  out  1  one-cycle pulse on an unknown command or a timeout.

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0. Address/data latches and the timeout counter clear. Assertion mid-command abandons the command immediately.
- Commands are decoded in IDLE on RX_D_VLD:
  - 0xAA WR: addr byte, then data byte.
  - 0xBB RD: addr byte; response is 1 byte.
  - 0xCC ALU_OP: operand A, operand B, fun byte; response is 2 bytes.
  - 0xDD ALU_NOP: fun byte; response is 2 bytes.
  - Any other value: CMD_ERR pulses and the FSM stays in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND, OP_A, OP_B, ALU_FN, ALU_WAIT, SEND_LO, SEND_HI.
- Register-file controls are combinational (Mealy on RX_D_VLD); the register file samples them on the next edge.
  - WR_ADDR: on RX_D_VLD, latch RX_P_DATA[ADDR_WIDTH-1:0] into addr_q, go to WR_DATA.
  - WR_DATA: on RX_D_VLD, WrEn=1, Address=addr_q, WrData=RX_P_DATA, go to IDLE.
  - RD_ADDR: on RX_D_VLD, RdEn=1, Address=RX_P_DATA[ADDR_WIDTH-1:0], go to RD_WAIT.
  - RD_WAIT: on RdData_Valid, latch RdData into tx_q, go to RD_SEND.
  - OP_A: on RX_D_VLD, WrEn=1, Address=0, WrData=RX_P_DATA, go to OP_B.
  - OP_B: same as OP_A with Address=1, go to ALU_FN.
  - ALU_FN: CLK_GATE_EN=1. On RX_D_VLD, ALU_EN=1 and ALU_FUN=RX_P_DATA[FUN_WIDTH-1:0], go to ALU_WAIT.
  - ALU_WAIT: CLK_GATE_EN=1. On OUT_Valid, latch ALU_OUT into res_q, go to SEND_LO.
  - SEND states and RD_SEND: if !FIFO_FULL, TX_D_VLD=1 for exactly one cycle.
    - SEND_LO sends res_q[7:0], then goes to SEND_HI.
    - SEND_HI sends res_q[15:8], then goes to IDLE.
    - RD_SEND sends tx_q, then goes to IDLE.
    - While FIFO_FULL is high, the FSM stalls and TX_D_VLD stays 0; no byte is lost.
- CLK_GATE_EN is 0 in every state other than ALU_FN and ALU_WAIT.
- Idle output values: Address, WrData, ALU_FUN and TX_P_DATA hold 0 when not driven.
- Timeout: the counter runs in RD_WAIT and ALU_WAIT.
  - When the count reaches TIMEOUT with no valid strobe, CMD_ERR pulses and the FSM returns to IDLE with no TX byte.
  - The counter clears on every state change.
- RX_D_VLD in RD_WAIT, ALU_WAIT or the SEND states: the byte is dropped silently and the state is unchanged.
- Simultaneous strobes: WrEn and RdEn are never high in the same cycle. TX_D_VLD is never high with FIFO_FULL.
- Latency, command byte to final TX strobe (FIFO not full):
  - RD: 3 cycles after the addr byte.
  - ALU: OUT_Valid + 2 cycles.

Decomposition:
- Shared package sys_pkg:
  - command opcodes: CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD.
  - state enum/localparams and the operand register addresses (OPA_ADDR=0, OPB_ADDR=1).
- Sub-module sys_ctrl_timeout: a loadable saturating counter with clear, enable and expired output.

Test Plan:
- WR, then RD: RX AA,05,3C, then BB,05. WrEn at addr 5 with data 0x3C, then RdEn at addr 5; model RdData=0x3C -> one TX_D_VLD with TX_P_DATA=0x3C.
- ALU_OP: RX CC,07,03,00. Writes 0x07 to addr 0 and 0x03 to addr 1, then ALU_EN with ALU_FUN=0. With ALU_OUT=0x000A -> TX 0x0A then 0x00; CLK_GATE_EN high only in ALU_FN/ALU_WAIT.
- FIFO back-pressure: ALU_NOP, DD,02. Hold FIFO_FULL=1 for 5 cycles in SEND_LO with ALU_OUT=0x1234 -> no TX_D_VLD while full, then 0x34 and 0x12 sent in order.
- Unknown opcode 0x55 -> CMD_ERR for one cycle, no WrEn/RdEn, FSM stays in IDLE. A following AA,01,FF executes normally.
- Timeout: BB,02 with RdData_Valid never asserted -> CMD_ERR exactly TIMEOUT cycles into RD_WAIT, no TX byte, back to IDLE.
- Reset mid-command: assert RST in OP_B after AA/CC bytes -> all outputs 0 asynchronously. After release, a CC sequence restarts from OP_A correctly.
